// File: rtl/dmem_responder.sv
// dmem_responder
// Responder end of the core's data-memory port. Holds a word-addressed data
// RAM plus a small MMIO window (cycle counter, debug TX FIFO, status,
// scratch). Load data is combinational so the core's MEM/WB stage can
// capture it at the next rising edge.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-high reset (RAM contents are kept)
//   data_ce_i    access enable from the core
//   data_we_i    1 = store, 0 = load (ignored when data_ce_i = 0)
//   data_addr_i  byte address, bits [1:0] ignored
//   data_i       store data
//   data_o       load data, 0 unless a load is in progress
//   dbg_valid_o  debug FIFO non-empty
//   dbg_data_o   debug FIFO head word (0 when empty)
//   dbg_ready_i  downstream accepts the head word
//
// Debug port handshake: a word transfers on every rising edge where
// dbg_valid_o and dbg_ready_i are both 1. dbg_valid_o does not depend on
// dbg_ready_i, and the head word stays stable until it is taken.
module dmem_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          FIFO_AW   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        dbg_valid_o,
  output logic [31:0] dbg_data_o,
  input  logic        dbg_ready_i
);

  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  // MMIO register offsets, in words
  localparam logic [13:0] OFF_CYCLE   = 14'd0;
  localparam logic [13:0] OFF_DBG_TX  = 14'd1;
  localparam logic [13:0] OFF_STATUS  = 14'd2;
  localparam logic [13:0] OFF_SCRATCH = 14'd3;

  logic [31:0]        r_ram [0:(1<<RAM_AW)-1];
  logic [31:0]        r_fifo [0:FIFO_DEPTH-1];
  logic [31:0]        r_cycle;
  logic [31:0]        r_scratch;
  logic               r_ovf;
  logic [FIFO_AW:0]   r_wr_ptr;
  logic [FIFO_AW:0]   r_rd_ptr;

  logic               w_mmio_sel;
  logic [13:0]        w_off;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic               w_load;
  logic               w_store;
  logic               w_empty;
  logic               w_full;
  logic [FIFO_AW:0]   w_count;
  logic               w_pop;
  logic               w_push_req;
  logic               w_push;
  logic               w_drop;
  logic [31:0]        w_status;
  logic [31:0]        w_mmio_rdata;
  logic               w_unused;

  assign w_unused   = ^data_addr_i[1:0];

  assign w_mmio_sel = (data_addr_i[31:16] == MMIO_BASE[31:16]);
  assign w_off      = data_addr_i[15:2];
  assign w_ram_idx  = data_addr_i[RAM_AW+1:2];
  assign w_load     = data_ce_i && !data_we_i;
  assign w_store    = data_ce_i && data_we_i;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_count = r_wr_ptr - r_rd_ptr;

  assign w_pop      = !w_empty && dbg_ready_i;
  assign w_push_req = w_store && w_mmio_sel && (w_off == OFF_DBG_TX);
  // A pop in the same edge frees the head slot, so a full FIFO can still accept.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign dbg_valid_o = !w_empty;
  assign dbg_data_o  = w_empty ? 32'h0 : r_fifo[r_rd_ptr[FIFO_AW-1:0]];

  assign w_status = {{(28-FIFO_AW){1'b0}}, w_count, r_ovf, w_full, w_empty};

  always_comb begin
    w_mmio_rdata = 32'h0;
    case (w_off)
      OFF_CYCLE:   w_mmio_rdata = r_cycle;
      OFF_STATUS:  w_mmio_rdata = w_status;
      OFF_SCRATCH: w_mmio_rdata = r_scratch;
      default:     w_mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    data_o = 32'h0;
    if (w_load) begin
      data_o = w_mmio_sel ? w_mmio_rdata : r_ram[w_ram_idx];
    end
  end

  // RAM and FIFO storage have no reset; only the control state does.
  always_ff @(posedge clk) begin
    if (w_store && !w_mmio_sel) begin
      r_ram[w_ram_idx] <= data_i;
    end
    if (w_push) begin
      r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle   <= 32'h0;
      r_scratch <= 32'h0;
      r_ovf     <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_store && w_mmio_sel && (w_off == OFF_STATUS) && data_i[2]) begin
        r_ovf <= 1'b0;
      end
      if (w_store && w_mmio_sel && (w_off == OFF_SCRATCH)) begin
        r_scratch <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        dbg_valid_o;
  logic [31:0] dbg_data_o;
  logic        dbg_ready_i;

  int n_checks;
  int n_errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .data_ce_i   (data_ce_i),
    .data_we_i   (data_we_i),
    .data_addr_i (data_addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .dbg_valid_o (dbg_valid_o),
    .dbg_data_o  (dbg_data_o),
    .dbg_ready_i (dbg_ready_i)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_cyc;
  logic [31:0] m_ram [int];
  logic [31:0] m_q[$];
  logic [31:0] m_scratch;
  logic        m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) m_cyc <= 32'h0;
    else     m_cyc <= m_cyc + 32'd1;
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int n;
    n = m_q.size();
    if (a[31:16] != 16'hFFFF) return m_ram[int'(a[11:2])];
    case (a[15:2])
      14'd0:   return m_cyc;
      14'd2:   return 32'(n == 0) | (32'(n == 4) << 1) | (32'(m_ovf) << 2) | (32'(n) << 3);
      14'd3:   return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_head();
    return (m_q.size() == 0) ? 32'h0 : m_q[0];
  endfunction

  task automatic model_reset();
    m_scratch = 32'h0;
    m_ovf     = 1'b0;
    m_q.delete();
  endtask

  // ---------------- driver ----------------
  // Entered and left at posedge+1. Samples outputs at posedge+3, then lets
  // one edge commit the access and updates the model for that edge.
  task automatic access(input logic ce, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy,
                        output logic [31:0] obs_d, output logic obs_v,
                        output logic [31:0] obs_head);
    logic pop;
    data_ce_i   = ce;
    data_we_i   = we;
    data_addr_i = a;
    data_i      = d;
    dbg_ready_i = rdy;
    #2;
    obs_d    = data_o;
    obs_v    = dbg_valid_o;
    obs_head = dbg_data_o;
    @(posedge clk);
    pop = (m_q.size() != 0) && rdy;
    if (ce && we) begin
      if (a[31:16] == 16'hFFFF) begin
        case (a[15:2])
          14'd1: begin
            if (m_q.size() < 4 || pop) m_q.push_back(d);
            else m_ovf = 1'b1;
          end
          14'd2: if (d[2]) m_ovf = 1'b0;
          14'd3: m_scratch = d;
          default: ;
        endcase
      end else begin
        m_ram[int'(a[11:2])] = d;
      end
    end
    if (pop) void'(m_q.pop_front());
    #1;
    data_ce_i = 1'b0;
    data_we_i = 1'b0;
  endtask

  logic [31:0] od, oh, ex;
  logic        ov;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    data_ce_i = 0; data_we_i = 0; data_addr_i = 0; data_i = 0; dbg_ready_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dbg_valid_o !== 1'b0 || dbg_data_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_dbg: valid=%b data=%h, want 0/0", dbg_valid_o, dbg_data_o);
    end
    rst = 1'b0;
    access(1, 0, 32'hFFFF_0008, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h1) begin
      n_errors++;
      $display("FAIL reset_status: got %h want 00000001", od);
    end
    access(1, 0, 32'hFFFF_000C, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_scratch: got %h want 0", od);
    end
    access(0, 0, 32'hFFFF_000C, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h0) begin
      n_errors++;
      $display("FAIL idle_data_o: got %h want 0", od);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] v0;
    rst = 1'b1;
    #2;
    rst = 1'b0;  // released mid-cycle at posedge+3; this cycle is cycle 1
    model_reset();
    #(-0);
    @(posedge clk); #1;  // cycle 2
    repeat (2) access(0, 0, 0, 0, 0, od, ov, oh);  // cycles 2,3
    access(1, 1, 32'hFFFF_0000, 32'h55, 0, od, ov, oh);  // cycle 4, write ignored
    ex = exp_read(32'hFFFF_0000);
    access(1, 0, 32'hFFFF_0000, 0, 0, od, ov, oh);  // cycle 5
    n_checks++;
    if (od !== 32'd4 || od !== ex) begin
      n_errors++;
      $display("FAIL cycle_5th: got %h want 4 (model %h)", od, ex);
    end
    // Wrap: preload the counter near its top and watch it roll over.
    @(negedge clk);
    force dut.r_cycle = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycle;
    @(posedge clk); #1;
    access(1, 0, 32'hFFFF_0000, 0, 0, od, ov, oh);
    v0 = od;
    access(1, 0, 32'hFFFF_0000, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== v0 + 32'd1) begin
      n_errors++;
      $display("FAIL cycle_wrap: got %h after %h", od, v0);
    end
    // Put the counter back in step with the model for later reads.
    rst = 1'b1; #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ram();
    access(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, od, ov, oh);
    access(1, 0, 32'h0000_0010, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL ram_read: got %h want deadbeef", od);
    end
    access(1, 0, 32'h0000_0013, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL ram_lowbits: got %h want deadbeef", od);
    end
    access(1, 0, 32'h0000_1010, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL ram_alias: got %h want deadbeef", od);
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] seq [4];
    seq = '{32'd1, 32'd2, 32'd3, 32'd4};
    for (int i = 1; i <= 5; i++) access(1, 1, 32'hFFFF_0004, i, 0, od, ov, oh);
    access(1, 0, 32'hFFFF_0008, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h26) begin
      n_errors++;
      $display("FAIL fifo_full_status: got %h want 00000026", od);
    end
    for (int i = 0; i < 4; i++) begin
      ex = exp_head();
      access(0, 0, 0, 0, 1, od, ov, oh);
      n_checks++;
      if (ov !== 1'b1 || oh !== seq[i] || oh !== ex) begin
        n_errors++;
        $display("FAIL fifo_drain[%0d]: valid=%b data=%h want 1/%h", i, ov, oh, seq[i]);
      end
    end
    access(1, 0, 32'hFFFF_0008, 0, 1, od, ov, oh);
    n_checks++;
    if (ov !== 1'b0 || oh !== 32'h0 || od !== 32'h5) begin
      n_errors++;
      $display("FAIL fifo_empty_status: valid=%b head=%h status=%h want 0/0/00000005", ov, oh, od);
    end
  endtask

  task automatic test_scratch_status();
    access(1, 1, 32'hFFFF_000C, 32'h1234_5678, 0, od, ov, oh);
    access(1, 0, 32'hFFFF_000C, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL scratch_rw: got %h want 12345678", od);
    end
    access(1, 1, 32'hFFFF_0008, 32'h4, 0, od, ov, oh);
    access(1, 0, 32'hFFFF_0008, 0, 0, od, ov, oh);
    n_checks++;
    if (od[2] !== 1'b0 || od !== 32'h1) begin
      n_errors++;
      $display("FAIL ovf_clear: got %h want 00000001", od);
    end
    access(1, 0, 32'hFFFF_0010, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h0) begin
      n_errors++;
      $display("FAIL unmapped_read: got %h want 0", od);
    end
    access(1, 0, 32'hFFFF_0004, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h0) begin
      n_errors++;
      $display("FAIL dbgtx_read: got %h want 0", od);
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] seq [4];
    seq = '{32'd6, 32'd7, 32'd8, 32'd9};
    for (int i = 5; i <= 8; i++) access(1, 1, 32'hFFFF_0004, i, 0, od, ov, oh);
    access(1, 1, 32'hFFFF_0004, 32'd9, 1, od, ov, oh);  // pops 5, pushes 9
    access(1, 0, 32'hFFFF_0008, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h22) begin
      n_errors++;
      $display("FAIL pushpop_status: got %h want 00000022", od);
    end
    for (int i = 0; i < 4; i++) begin
      access(0, 0, 0, 0, 1, od, ov, oh);
      n_checks++;
      if (oh !== seq[i]) begin
        n_errors++;
        $display("FAIL pushpop_order[%0d]: got %h want %h", i, oh, seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) access(1, 1, 32'hFFFF_0004, 32'hA0 + i, 0, od, ov, oh);
    access(1, 1, 32'hFFFF_000C, 32'd7, 0, od, ov, oh);
    data_ce_i = 1; data_we_i = 0; data_addr_i = 32'hFFFF_0008;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (dbg_valid_o !== 1'b0 || dbg_data_o !== 32'h0 || data_o !== 32'h1) begin
      n_errors++;
      $display("FAIL midreset_async: valid=%b head=%h status=%h want 0/0/00000001",
               dbg_valid_o, dbg_data_o, data_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    access(1, 0, 32'hFFFF_000C, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset_scratch: got %h want 0", od);
    end
    access(1, 0, 32'hFFFF_0008, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'h1) begin
      n_errors++;
      $display("FAIL midreset_status: got %h want 00000001", od);
    end
    access(1, 0, 32'h0000_0010, 0, 0, od, ov, oh);
    n_checks++;
    if (od !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL midreset_ram: got %h want deadbeef", od);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic        we, rdy, ce;
    logic [31:0] eh;
    logic        ev;
    for (int i = 0; i < 16; i++) access(1, 1, 32'h100 + 4 * i, $urandom, 0, od, ov, oh);
    for (int i = 0; i < 300; i++) begin
      ce  = ($urandom_range(0, 7) != 0);
      we  = $urandom_range(0, 1);
      rdy = $urandom_range(0, 1);
      d   = $urandom;
      if ($urandom_range(0, 1) == 0)
        a = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      else
        a = 32'hFFFF_0000 + 4 * $urandom_range(0, 5);
      if (a[15:2] == 14'd2 && $urandom_range(0, 3) != 0) d[2] = 1'b0;
      ex = (ce && !we) ? exp_read(a) : 32'h0;
      ev = (m_q.size() != 0);
      eh = exp_head();
      access(ce, we, a, d, rdy, od, ov, oh);
      n_checks++;
      if (od !== ex || ov !== ev || oh !== eh) begin
        n_errors++;
        $display("FAIL random[%0d] addr=%h: data_o=%h valid=%b head=%h want %h/%b/%h",
                 i, a, od, ov, oh, ex, ev, eh);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_ram();
    test_cycle();
    model_reset();
    test_fifo_overflow();
    test_scratch_status();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
